// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder slice: FSM encoding,
// word geometry, wait counter width and the byte-enable legality helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

  // Byte-enable patterns that describe a naturally sized access
  localparam logic [3:0] LEGAL_BE [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

  function automatic logic is_misaligned(logic [1:0] lo, logic [3:0] be);
    logic legal;
    legal = (be == 4'h0);
    for (int i = 0; i < 7; i++) begin
      if (be == LEGAL_BE[i]) legal = 1'b1;
    end
    return !legal
        || (be == 4'hF && lo != 2'b00)
        || ((be == 4'h3 || be == 4'hC) && lo[0]);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the memory responder (slave):
// valid/ready request channel, valid/ready response channel and a busy flag.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous write with per-byte enables and a
// combinational read of the same word index.
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: storage has no reset on purpose; contents survive a reset and the
  // array maps onto plain RAM without a clear path.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[widx];

endmodule

// File: rtl/dmem_responder.sv
// Slow-memory responder for the core load/store port: one outstanding request,
// WAIT_CYCLES wait states, byte-enabled stores, range fault and optional
// alignment fault (enabled by defining DMEM_ALIGN_CHECK_EN).
module dmem_responder import dmem_pkg::*; #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic            lat_we;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_be;

  logic            acc_we;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_be;
  logic [31:0]     off;
  logic            misalign;
  logic            fault;
  logic            access;
  logic            mem_we;
  logic [31:0]     mem_rdata;
  logic [31:0]     load_data;

  // With zero wait states the access happens on the accept edge, so the
  // checks must look at the live request instead of the latch.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_we    = lat_we;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_be    = lat_be;
    if (state == S_IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_be    = bus.req_be;
    end
  end

  assign off = acc_addr - BASE_ADDR;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = is_misaligned(off[1:0], acc_be);
`else
  logic unused_lo;
  assign unused_lo = ^off[1:0];
  assign misalign  = 1'b0;
`endif

  assign fault  = (off[31:2] >= 30'(DEPTH_WORDS)) || misalign;
  assign access = !reset
               && ((state == S_IDLE && bus.req_valid && WAIT_CYCLES == 0)
                || (state == S_WAIT && cnt == CNT_W'(1)));
  assign mem_we    = access && acc_we && !fault;
  assign load_data = (acc_we || fault) ? 32'h0 : mem_rdata;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (acc_be),
    .widx  (off[IDX_W+1:2]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  // rsp_valid rises one cycle after entering RESP, giving accept-to-valid
  // latency of WAIT_CYCLES+1 edges for every WAIT_CYCLES value.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_be        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_be    <= bus.req_be;
            if (WAIT_CYCLES == 0) begin
              state         <= S_RESP;
              bus.rsp_rdata <= load_data;
              bus.rsp_err   <= fault;
            end else begin
              cnt   <= CNT_W'(WAIT_CYCLES);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state         <= S_RESP;
            bus.rsp_rdata <= load_data;
            bus.rsp_err   <= fault;
          end
          cnt <= cnt - CNT_W'(1);
        end
        S_RESP: begin
          if (!bus.rsp_valid) begin
            bus.rsp_valid <= 1'b1;
          end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of single transactions plus
// hand-written stall, reset and reset-vs-handshake sequences.
module tb_dmem_responder;

  localparam int WAIT = 2;
  localparam int LAT  = WAIT + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (256),
    .BASE_ADDR   (32'h0),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Accept edge T is the posedge inside this task; returns at T+1ns.
  task automatic send(input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_send", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Counts posedges after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!bus.rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int cyc;
    send(we, addr, wdata, be);
    wait_rsp(cyc);
    check({name, "_latency"}, 32'(cyc), 32'(LAT));
    check({name, "_rdata"}, bus.rsp_rdata, exp_rdata);
    check({name, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    handshake();
  endtask

  initial begin
    int cyc;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,  32'h0000AA00, 4'h2, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,  32'h0,        4'h1, 32'h1122AA44, 1'b0};
    vecs[5]  = '{1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h400, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h0,   32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b1, 32'h24,  32'h12345678, 4'hF, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 32'h24,  32'hAABBCCDD, 4'h0, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h24,  32'h0,        4'h0, 32'h12345678, 1'b0};
    vecs[12] = '{1'b0, 32'hFFFFFFFC, 32'h0,   4'hF, 32'h0,        1'b1};
    vecs[13] = '{1'b0, 32'h3FC, 32'h0,        4'hF, 32'h0,        1'b0};
    vecs[14] = '{1'b1, 32'h3FC, 32'h0A0B0C0D, 4'hC, 32'h0,        1'b0};
    vecs[15] = '{1'b1, 32'h3FC, 32'h01020304, 4'h3, 32'h0,        1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
    vecs[16] = '{1'b1, 32'h22,  32'h55667788, 4'hF, 32'h0,        1'b1};
    vecs[17] = '{1'b0, 32'h20,  32'h0,        4'hF, 32'h1122AA44, 1'b0};
`else
    vecs[16] = '{1'b1, 32'h22,  32'h55667788, 4'hF, 32'h0,        1'b0};
    vecs[17] = '{1'b0, 32'h20,  32'h0,        4'hF, 32'h55667788, 1'b0};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_rsp_err",   32'(bus.rsp_err), 32'd0);
    check("reset_busy",      32'(bus.busy), 32'd0);

    // Word 0x3FC is written only by halves, so a full-word readback is
    // deterministic once both halves are set; vec 13 loads it before that,
    // so write it fully first.
    do_req("init_3fc", 1'b1, 32'h3FC, 32'h0, 4'hF, 32'h0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err);
    end
    do_req("halves_3fc", 1'b0, 32'h3FC, 32'h0, 4'hF, 32'h0A0B0304, 1'b0);

    // Stall in RESP for 5 cycles with a competing request present
    send(1'b0, 32'h10, 32'h0, 4'hF);
    wait_rsp(cyc);
    check("stall_latency", 32'(cyc), 32'(LAT));
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h0BADF00D;
    bus.req_be    = 4'hF;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("stall%0d_rdata", k), bus.rsp_rdata, 32'hDEADBEEF);
      check($sformatf("stall%0d_req_ready", k), 32'(bus.req_ready), 32'd0);
      check($sformatf("stall%0d_busy", k), 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    handshake();
    @(negedge clk);
    check("post_stall_busy", 32'(bus.busy), 32'd0);
    check("post_stall_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    do_req("stall_no_write", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

    // Reset during WAIT drops the uncommitted store
    do_req("pre30", 1'b1, 32'h30, 32'h5, 4'hF, 32'h0, 1'b0);
    send(1'b1, 32'h30, 32'h99, 4'hF);
    @(negedge clk);
    check("in_wait_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("wait_rst_busy", 32'(bus.busy), 32'd0);
    check("wait_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("wait_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    do_req("wait_rst_lw30", 1'b0, 32'h30, 32'h0, 4'hF, 32'h5, 1'b0);

    // Reset in RESP discards the response but the store persists
    send(1'b1, 32'h34, 32'h77, 4'hF);
    wait_rsp(cyc);
    check("resp_rst_latency", 32'(cyc), 32'(LAT));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("resp_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("resp_rst_busy", 32'(bus.busy), 32'd0);
    do_req("resp_rst_lw34", 1'b0, 32'h34, 32'h0, 4'hF, 32'h77, 1'b0);

    // Reset coinciding with a request: nothing is latched
    do_req("pre38", 1'b1, 32'h38, 32'h1, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h38;
    bus.req_wdata = 32'hFFFF0000;
    bus.req_be    = 4'hF;
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("sim_rst_busy", 32'(bus.busy), 32'd0);
    check("sim_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (4) @(negedge clk);
    check("sim_rst_still_idle", 32'(bus.busy), 32'd0);
    do_req("sim_rst_lw38", 1'b0, 32'h38, 32'h0, 4'hF, 32'h1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
